// File: rtl/gdsp_pkg.sv
// Shared DSP constants and types for the clk_dsp domain.
// Includes the 16-QAM slicer level and the EVM result type.
package gdsp_pkg;

  localparam int DATA_W        = 12;
  localparam int QAM16_LEVEL_A = 160;
  localparam int WIN_LOG2      = 10;
  localparam int SETTLE_N      = 64;
  localparam int TH1           = 64;
  localparam int TH2           = 512;
  localparam int TH3           = 2048;

  localparam int E_W   = DATA_W + 1;
  localparam int SQ_W  = 2 * E_W + 1;
  localparam int ACC_W = SQ_W + WIN_LOG2;
  localparam int MSE_W = ACC_W - WIN_LOG2;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [E_W-1:0]    err_t;
  typedef logic [MSE_W-1:0]         evm_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_MEAS   = 2'd2
  } evm_state_e;

  function automatic logic [1:0] evm_grade(
    input evm_t m
  );
    logic [1:0] g;
    if (m < evm_t'(TH1))      g = 2'd0;
    else if (m < evm_t'(TH2)) g = 2'd1;
    else if (m < evm_t'(TH3)) g = 2'd2;
    else                      g = 2'd3;
    return g;
  endfunction

endpackage

// File: rtl/qam16_slicer.sv
// One-axis 16-QAM hard slicer: nearest of {-3A,-A,A,3A} and the error.
// Samples exactly on a threshold resolve to the more positive point.
module qam16_slicer
  import gdsp_pkg::*;
(
  input  logic signed [DATA_W-1:0] x_i,
  output logic signed [DATA_W-1:0] ideal_o,
  output logic signed [E_W-1:0]    err_o
);

  localparam sample_t P1 = sample_t'(QAM16_LEVEL_A);
  localparam sample_t P3 = sample_t'(3 * QAM16_LEVEL_A);
  localparam sample_t N1 = sample_t'(-QAM16_LEVEL_A);
  localparam sample_t N3 = sample_t'(-3 * QAM16_LEVEL_A);
  localparam sample_t T2 = sample_t'(2 * QAM16_LEVEL_A);
  localparam sample_t M2 = sample_t'(-2 * QAM16_LEVEL_A);

  logic hi;
  logic pos;
  logic ge_m2;

  assign hi    = (x_i >= T2);
  assign pos   = ~x_i[DATA_W-1];
  assign ge_m2 = (x_i >= M2);

  always_comb begin
    ideal_o = N3;
    unique case (1'b1)
      hi:              ideal_o = P3;
      (pos && !hi):    ideal_o = P1;
      (!pos && ge_m2): ideal_o = N1;
      (!ge_m2):        ideal_o = N3;
    endcase
  end

  assign err_o = {x_i[DATA_W-1], x_i}
               - {ideal_o[DATA_W-1], ideal_o};

endmodule

// File: rtl/evm_monitor.sv
// 16-QAM EVM monitor: windowed mean |e|^2, link grade and lock FSM.
// Define EVM_PEAK_HOLD_EN to build the evm_peak max-hold register.
module evm_monitor
  import gdsp_pkg::*;
(
  input  logic                    clk_dsp,
  input  logic                    sys_rst_n,
  input  logic                    en,
  input  logic signed [DATA_W-1:0] demod_I,
  input  logic signed [DATA_W-1:0] demod_Q,
  input  logic                    demod_valid,
  input  logic                    demod_lock,
  output logic [MSE_W-1:0]        evm_mse,
  output logic                    evm_valid,
  output logic [1:0]              quality,
  output logic                    meas_active,
  output logic [MSE_W-1:0]        evm_peak
);

  localparam int SET_W = $clog2(SETTLE_N);

  evm_state_e          state_q;
  logic [SET_W-1:0]    set_cnt_q;
  logic [WIN_LOG2-1:0] win_cnt_q;
  logic                v1_q;
  logic                v2_q;
  err_t                eI_q;
  err_t                eQ_q;
  logic [SQ_W-1:0]     sq_q;
  logic [ACC_W-1:0]    acc_q;
  evm_t                mse_q;
  logic                valid_q;
  logic [1:0]          qual_q;
  logic                meas_q;

  sample_t             unused_ideal_i;
  sample_t             unused_ideal_q;
  err_t                eI_d;
  err_t                eQ_d;
  logic                accept;
  logic                run;
  logic signed [2*E_W-1:0] pI;
  logic signed [2*E_W-1:0] pQ;
  logic [SQ_W-1:0]     sq_d;
  logic [ACC_W-1:0]    acc_sum;
  evm_t                mse_d;

  qam16_slicer u_slc_i (
    .x_i     (demod_I),
    .ideal_o (unused_ideal_i),
    .err_o   (eI_d)
  );

  qam16_slicer u_slc_q (
    .x_i     (demod_Q),
    .ideal_o (unused_ideal_q),
    .err_o   (eQ_d)
  );

  assign run     = en & demod_lock;
  assign accept  = demod_valid & (state_q == ST_MEAS);
  assign pI      = eI_q * eI_q;
  assign pQ      = eQ_q * eQ_q;
  assign sq_d    = {1'b0, pI} + {1'b0, pQ};
  assign acc_sum = acc_q + {{WIN_LOG2{1'b0}}, sq_q};
  assign mse_d   = acc_sum[ACC_W-1:WIN_LOG2];

`ifdef EVM_PEAK_HOLD_EN
  evm_t peak_q;

  always_ff @(posedge clk_dsp or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      peak_q <= '0;
    end else if (run && state_q == ST_MEAS
                 && v2_q && (&win_cnt_q)
                 && mse_d > peak_q) begin
      peak_q <= mse_d;
    end
  end

  assign evm_peak = peak_q;
`else
  assign evm_peak = '0;
`endif

  always_ff @(posedge clk_dsp or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      set_cnt_q <= '0;
      win_cnt_q <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      eI_q      <= '0;
      eQ_q      <= '0;
      sq_q      <= '0;
      acc_q     <= '0;
      mse_q     <= '0;
      valid_q   <= 1'b0;
      qual_q    <= 2'd0;
      meas_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!run) begin
        // Lock/enable loss: drop the partial window and flush S1/S2.
        state_q   <= ST_IDLE;
        meas_q    <= 1'b0;
        set_cnt_q <= '0;
        win_cnt_q <= '0;
        v1_q      <= 1'b0;
        v2_q      <= 1'b0;
        acc_q     <= '0;
      end else begin
        v1_q <= accept;
        v2_q <= v1_q;
        if (accept) begin
          eI_q <= eI_d;
          eQ_q <= eQ_d;
        end
        if (v1_q) sq_q <= sq_d;
        unique case (state_q)
          ST_IDLE: begin
            state_q   <= ST_SETTLE;
            set_cnt_q <= '0;
            win_cnt_q <= '0;
            acc_q     <= '0;
          end
          ST_SETTLE: begin
            if (demod_valid) begin
              if (set_cnt_q == SET_W'(SETTLE_N - 1)) begin
                state_q   <= ST_MEAS;
                meas_q    <= 1'b1;
                set_cnt_q <= '0;
              end else begin
                set_cnt_q <= set_cnt_q + 1'b1;
              end
            end
          end
          ST_MEAS: begin
            if (v2_q) begin
              win_cnt_q <= win_cnt_q + 1'b1;
              if (&win_cnt_q) begin
                mse_q   <= mse_d;
                qual_q  <= evm_grade(mse_d);
                valid_q <= 1'b1;
                acc_q   <= '0;
              end else begin
                acc_q <= acc_sum;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            meas_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign evm_mse     = mse_q;
  assign evm_valid   = valid_q;
  assign quality     = qual_q;
  assign meas_active = meas_q;

endmodule

// File: tb/tb_evm_monitor.sv
// Randomised bench for evm_monitor against a window-level EVM model.
// Honours EVM_PEAK_HOLD_EN for the evm_peak expectations.
module tb_evm_monitor;

  logic              clk_dsp     = 1'b0;
  logic              sys_rst_n   = 1'b0;
  logic              en          = 1'b0;
  logic signed [11:0] demod_I    = '0;
  logic signed [11:0] demod_Q    = '0;
  logic              demod_valid = 1'b0;
  logic              demod_lock  = 1'b0;
  logic [26:0]       evm_mse;
  logic              evm_valid;
  logic [1:0]        quality;
  logic              meas_active;
  logic [26:0]       evm_peak;

  evm_monitor dut (
    .clk_dsp     (clk_dsp),
    .sys_rst_n   (sys_rst_n),
    .en          (en),
    .demod_I     (demod_I),
    .demod_Q     (demod_Q),
    .demod_valid (demod_valid),
    .demod_lock  (demod_lock),
    .evm_mse     (evm_mse),
    .evm_valid   (evm_valid),
    .quality     (quality),
    .meas_active (meas_active),
    .evm_peak    (evm_peak)
  );

  always #5 clk_dsp = ~clk_dsp;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint exp_q[$];
  int     vt[$];
  int     m_settle = 0;
  int     m_wcnt = 0;
  longint m_sum = 0;
  longint m_peak = 0;
  int     cyc = 0;
  int     nvalid = 0;
  bit     run = 1'b0;
  int     pts[4] = '{-480, -160, 160, 480};

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Nearest constellation point; ties go to the later (more positive) one.
  function automatic int slice(int x);
    int best = pts[0];
    for (int k = 0; k < 4; k++)
      if (iabs(x - pts[k]) <= iabs(x - best)) best = pts[k];
    return best;
  endfunction

  function automatic int grade(longint m);
    if (m < 64) return 0;
    if (m < 512) return 1;
    if (m < 2048) return 2;
    return 3;
  endfunction

  function automatic void model_clear();
    m_settle = 0;
    m_wcnt   = 0;
    m_sum    = 0;
  endfunction

  always @(negedge clk_dsp) begin
    if (run) begin
      longint e;
      cyc++;
      if (evm_valid) begin
        nvalid++;
        vt.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected evm_valid: got 1 want 0");
        end else begin
          e = exp_q.pop_front();
`ifdef EVM_PEAK_HOLD_EN
          if (e > m_peak) m_peak = e;
`endif
          chk("evm_mse", evm_mse, e);
          chk("quality", quality, grade(e));
        end
      end
      chk("evm_peak", evm_peak, m_peak);
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk_dsp); #1;
      demod_valid = 1'b0;
    end
  endtask

  task automatic send(int i, int q);
    longint ei, eq;
    @(posedge clk_dsp); #1;
    demod_I     = 12'(i);
    demod_Q     = 12'(q);
    demod_valid = 1'b1;
    if (m_settle < 64) begin
      m_settle++;
    end else begin
      ei = i - slice(i);
      eq = q - slice(q);
      m_sum += ei * ei + eq * eq;
      m_wcnt++;
      if (m_wcnt == 1024) begin
        exp_q.push_back(m_sum >> 10);
        m_sum  = 0;
        m_wcnt = 0;
      end
    end
  endtask

  task automatic sym(int mode, int off, bit gap);
    int i, q;
    i = pts[$urandom_range(0, 3)];
    q = pts[$urandom_range(0, 3)];
    case (mode)
      0: begin i += off; q += off; end
      1: begin
        i += int'($urandom_range(0, 40)) - 20;
        q += int'($urandom_range(0, 40)) - 20;
      end
      2: begin
        i = int'($urandom_range(0, 4095)) - 2048;
        q = int'($urandom_range(0, 4095)) - 2048;
      end
      3: i = 320;
      default: begin i = -2048; q = -2048; end
    endcase
    if (gap && $urandom_range(0, 1) == 1)
      idle($urandom_range(1, 2));
    send(i, q);
  endtask

  task automatic syms(int n, int mode, int off, bit gap);
    repeat (n) sym(mode, off, gap);
  endtask

  task automatic drain(string nm);
    idle(1);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++)
      idle(1);
    idle(2);
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic lock_up();
    @(posedge clk_dsp); #1;
    demod_valid = 1'b0;
    demod_lock  = 1'b1;
    model_clear();
    idle(2);
  endtask

  task automatic lock_down(string nm);
    @(posedge clk_dsp); #1;
    demod_valid = 1'b0;
    demod_lock  = 1'b0;
    model_clear();
    @(posedge clk_dsp); #1;
    chk(nm, meas_active, 0);
  endtask

  task automatic do_reset();
    demod_valid = 1'b0;
    demod_lock  = 1'b0;
    en          = 1'b0;
    sys_rst_n   = 1'b0;
    model_clear();
    exp_q.delete();
    m_peak = 0;
    repeat (3) @(posedge clk_dsp);
    @(negedge clk_dsp);
    chk("rst evm_mse", evm_mse, 0);
    chk("rst evm_valid", evm_valid, 0);
    chk("rst quality", quality, 0);
    chk("rst meas_active", meas_active, 0);
    chk("rst evm_peak", evm_peak, 0);
    #1 sys_rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    do_reset();
    run = 1'b1;
    en  = 1'b1;

    lock_up();
    syms(64, 1, 0, 1'b1);
    syms(1024, 0, 0, 1'b1);
    drain("t1 drain");
    chk("t1 mse", evm_mse, 0);
    chk("t1 quality", quality, 0);
    chk("t1 meas_active", meas_active, 1);

    syms(1024, 0, 10, 1'b1);
    drain("t2 drain");
    chk("t2 mse", evm_mse, 200);
    chk("t2 quality", quality, 1);

    syms(1024, 3, 0, 1'b1);
    drain("t2b drain");
    chk("t2b mse", evm_mse, 25600);
    chk("t2b quality", quality, 3);

    n0 = nvalid;
    syms(500, 1, 0, 1'b1);
    lock_down("t3 meas_active");
    idle(10);
    chk("t3 no valid", nvalid - n0, 0);
    lock_up();
    syms(64 + 1023, 1, 0, 1'b1);
    idle(6);
    chk("t3 early valid", nvalid - n0, 0);
    sym(1, 0, 1'b0);
    drain("t3 drain");
    chk("t3 one valid", nvalid - n0, 1);

    vt.delete();
    syms(3 * 1024, 1, 0, 1'b0);
    drain("t4 drain");
    chk("t4 pulses", vt.size(), 3);
    if (vt.size() == 3) begin
      chk("t4 gap01", vt[1] - vt[0], 1024);
      chk("t4 gap12", vt[2] - vt[1], 1024);
    end

    syms(1024, 4, 0, 1'b1);
    drain("t5 drain");
    chk("t5 mse", evm_mse, 4917248);
    chk("t5 quality", quality, 3);

    syms(2048, 2, 0, 1'b1);
    drain("t7 drain");

    do_reset();
    en = 1'b1;
    lock_up();
    syms(64, 1, 0, 1'b1);
    syms(1024, 0, 30, 1'b1);
    drain("t6a drain");
    chk("t6a mse", evm_mse, 1800);
    chk("t6a quality", quality, 2);
    syms(1024, 0, 10, 1'b1);
    drain("t6b drain");
    chk("t6b mse", evm_mse, 200);
`ifdef EVM_PEAK_HOLD_EN
    chk("t6 peak", evm_peak, 1800);
`else
    chk("t6 peak", evm_peak, 0);
`endif

    @(posedge clk_dsp); #1;
    en = 1'b0;
    @(posedge clk_dsp); #1;
    chk("en off meas_active", meas_active, 0);
    idle(4);
    run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
